// File: rtl/popcount_serial.sv
// popcount_serial: multi-cycle popcount over CHUNK-bit slices with count/onehot/onehot0 results.
// Define POPCOUNT_FIRST_EN to add the out_first (lowest set bit index) port.
module popcount_serial #(
    parameter int WIDTH = 80,
    parameter int CHUNK = 16,
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_onehot,
    output logic             out_onehot0
`ifdef POPCOUNT_FIRST_EN
    ,
    output logic [CW-1:0]    out_first
`endif
);
    localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    localparam int PW = NCHUNK * CHUNK;
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
    state_t        state_q;
    logic [PW-1:0] word_q;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] acc_q, acc_d, count_q;
    logic          ready_q, valid_q, onehot_q, onehot0_q;
    logic [CHUNK-1:0] chunk;
    logic [CW-1:0] chunk_cnt;
    logic          last;
    always_comb begin
        chunk = CHUNK'(word_q >> (int'(idx_q) * CHUNK));
        chunk_cnt = '0;
        for (int j = 0; j < CHUNK; j++) chunk_cnt = chunk_cnt + CW'(chunk[j]);
        acc_d = acc_q + chunk_cnt;
        last = idx_q == IW'(NCHUNK - 1);
    end
`ifdef POPCOUNT_FIRST_EN
    logic [CW-1:0] first_q, out_first_q, first_d, chunk_lo;
    logic          found_q;
    always_comb begin
        chunk_lo = '0;
        for (int j = CHUNK - 1; j >= 0; j--) if (chunk[j]) chunk_lo = CW'(j);
        first_d = found_q ? first_q : (|chunk ? CW'(int'(idx_q) * CHUNK) + chunk_lo : '0);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            first_q <= '0;
            found_q <= 1'b0;
            out_first_q <= '0;
        end else if (state_q == IDLE && in_valid && ready_q) begin
            first_q <= '0;
            found_q <= 1'b0;
        end else if (state_q == COUNT) begin
            first_q <= first_d;
            found_q <= found_q | (|chunk);
            if (last) out_first_q <= first_d;
        end
    end
    assign out_first = out_first_q;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            word_q    <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            onehot_q  <= 1'b0;
            onehot0_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid && ready_q) begin
                    word_q  <= PW'(in_word);
                    acc_q   <= '0;
                    idx_q   <= '0;
                    ready_q <= 1'b0;
                    state_q <= COUNT;
                end
                COUNT: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + IW'(1);
                    if (last) begin
                        count_q   <= acc_d;
                        onehot_q  <= acc_d == CW'(1);
                        onehot0_q <= acc_d <= CW'(1);
                        valid_q   <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_ready    = ready_q;
    assign out_valid   = valid_q;
    assign out_count   = count_q;
    assign out_onehot  = onehot_q;
    assign out_onehot0 = onehot0_q;
endmodule

// File: tb/tb_popcount_serial.sv
// tb_popcount_serial: scoreboard bench for popcount_serial (80/16 main instance, 50/16 partial-chunk instance).
module tb_popcount_serial;
    typedef struct {
        logic [6:0] cnt;
        logic       oh;
        logic       oh0;
        logic [6:0] first;
    } exp_t;
    logic        clk = 0, reset = 1, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid, out_onehot, out_onehot0;
    logic [79:0] in_word = '0;
    logic [6:0]  out_count;
    logic        v50 = 0, r50 = 0, ir50, ov50, oh50, oh050;
    logic [49:0] w50 = '0;
    logic [5:0]  c50;
    exp_t        sb[$];
    int          n_chk = 0, n_fail = 0;
`ifdef POPCOUNT_FIRST_EN
    logic [6:0]  out_first;
    logic [5:0]  f50;
`endif
    always #5 clk = ~clk;
    popcount_serial #(.WIDTH(80), .CHUNK(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .out_onehot(out_onehot), .out_onehot0(out_onehot0)
`ifdef POPCOUNT_FIRST_EN
        , .out_first(out_first)
`endif
    );
    popcount_serial #(.WIDTH(50), .CHUNK(16)) dut50 (
        .clk(clk), .reset(reset), .in_valid(v50), .in_ready(ir50), .in_word(w50),
        .out_valid(ov50), .out_ready(r50), .out_count(c50),
        .out_onehot(oh50), .out_onehot0(oh050)
`ifdef POPCOUNT_FIRST_EN
        , .out_first(f50)
`endif
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic exp_t model(input logic [79:0] w);
        exp_t e;
        int c = 0;
        e.first = '0;
        for (int i = 79; i >= 0; i--) if (w[i]) begin c++; e.first = 7'(i); end
        e.cnt = 7'(c);
        e.oh = c == 1;
        e.oh0 = c <= 1;
        return e;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [79:0] w);
        int n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        check("accept_ready", in_ready, 1);
        in_valid = 1;
        in_word = w;
        tick();
        in_valid = 0;
        sb.push_back(model(w));
    endtask
    task automatic recv(input int lat);
        exp_t e;
        int n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        check("latency", n, lat);
        if (sb.size() == 0) check("sb_nonempty", 0, 1);
        else begin
            e = sb.pop_front();
            check("count", out_count, e.cnt);
            check("onehot", out_onehot, e.oh);
            check("onehot0", out_onehot0, e.oh0);
`ifdef POPCOUNT_FIRST_EN
            check("first", out_first, e.first);
`endif
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        check("valid_drop", out_valid, 0);
        check("ready_back", in_ready, 1);
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
    initial begin
        logic [79:0] wb;
        int n;
        repeat (3) tick();
        reset = 0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_count", out_count, 0);
        check("rst_onehot", out_onehot, 0);
        check("rst_onehot0", out_onehot0, 0);
        send(80'h0);
        check("no_early_valid", out_valid, 0);
        recv(5);
        send(~80'h0);
        recv(5);
        send(80'h0100_0000_0f00_00f0_0000);
        recv(5);
        send(80'h10_0000_0000_0000_0000);
        recv(5);
        for (int i = 0; i < 4; i++) begin
            send({$urandom, $urandom, 16'($urandom)});
            recv(5);
        end
        send(80'h8000_0000_0000_0000_0001);
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        check("bp_latency", n, 5);
        wb = 80'h0000_ffff_0000_0000_0003;
        in_valid = 1;
        in_word = wb;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_count", out_count, 2);
            check("bp_in_ready", in_ready, 0);
        end
        void'(sb.pop_front());
        out_ready = 1;
        tick();
        out_ready = 0;
        check("bp_idle_ready", in_ready, 1);
        tick();
        in_valid = 0;
        sb.push_back(model(wb));
        check("bp_accepted", in_ready, 0);
        recv(5);
        send(80'h1234_5678_9abc_def0_1357);
        void'(sb.pop_front());
        tick();
        tick();
        reset = 1;
        tick();
        reset = 0;
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_valid", out_valid, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (out_valid) n++; end
        check("mid_rst_no_result", n, 0);
        v50 = 1;
        w50 = 50'h01_1111_0001;
        tick();
        v50 = 0;
        n = 0;
        while (!ov50 && n < 50) begin tick(); n++; end
        check("w50_latency", n, 4);
        check("w50_count", c50, 6);
        check("w50_onehot", oh50, 0);
        check("w50_onehot0", oh050, 0);
`ifdef POPCOUNT_FIRST_EN
        check("w50_first", f50, 0);
`endif
        r50 = 1;
        tick();
        r50 = 0;
        check("w50_valid_drop", ov50, 0);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
